// File: rtl/deserializer.sv
// deserializer: collects a qualified MSB-first serial stream into DATA_W-bit words.
// Define DESER_FLUSH_EN to add flush_i / deser_mod_o for emitting left-aligned partial words.
module deserializer #(
   parameter int DATA_W = 16
) (
   input  logic                      clk_i,
   input  logic                      srst_i,
   input  logic                      data_i,
   input  logic                      data_val_i,
`ifdef DESER_FLUSH_EN
   input  logic                      flush_i,
   output logic [$clog2(DATA_W)-1:0] deser_mod_o,
`endif
   output logic [DATA_W-1:0]         deser_data_o,
   output logic                      deser_data_val_o,
   output logic                      busy_o
);
   localparam int CW = $clog2(DATA_W) + 1;
   logic [CW-1:0]     cnt, cnt_inc;
   logic [DATA_W-1:0] sr, sr_nxt, word;
   logic              full, flush, emit;
   always_comb begin
      sr_nxt  = data_val_i ? {sr[DATA_W-2:0], data_i} : sr;
      cnt_inc = data_val_i ? cnt + CW'(1) : cnt;
      full    = data_val_i && (cnt == CW'(DATA_W - 1));
`ifdef DESER_FLUSH_EN
      // the bit arriving with a flush is taken first, then held bits are left-aligned
      flush   = flush_i && !full && (cnt_inc != '0);
      word    = flush ? sr_nxt << (CW'(DATA_W) - cnt_inc) : sr_nxt;
`else
      flush   = 1'b0;
      word    = sr_nxt;
`endif
      emit    = full || flush;
   end
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         sr               <= '0;
         cnt              <= '0;
         busy_o           <= 1'b0;
         deser_data_o     <= '0;
         deser_data_val_o <= 1'b0;
`ifdef DESER_FLUSH_EN
         deser_mod_o      <= '0;
`endif
      end else begin
         sr               <= sr_nxt;
         cnt              <= emit ? '0 : cnt_inc;
         busy_o           <= !emit && (cnt_inc != '0);
         deser_data_val_o <= emit;
         if (emit) deser_data_o <= word;
`ifdef DESER_FLUSH_EN
         if (emit) deser_mod_o <= flush ? cnt_inc[CW-2:0] : '0;
`endif
      end
   end
endmodule
